seg7_scan_ctrl: RTL
===================

Name: seg7_scan_ctrl

Overview:
Time-multiplexed scan controller for an N-digit common-anode 7-segment display. One hex-to-segment decoder is shared across all digits. The block:
- cycles the digit index on a prescaled refresh tick;
- drives active-low anodes and segments;
- inserts an anti-ghosting guard at the start of each slot;
- takes new display values through a ready/load handshake that is tear-free at frame boundaries.

It sits between the numeric datapath and the board display pins.

Parameters:
N_DIGITS, 4, number of multiplexed digits (2..8)
PRESCALE, 50000, clk cycles per digit slot (>= GUARD+2)
GUARD, 2, cycles at slot start with all anodes off (>= 0)

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
en  in  1  scan enable
load  in  1  update request; accepted only when ready=1
value  in  4*N_DIGITS  hex nibbles; nibble k drives digit k; digit 0 is rightmost/least significant
dp_in  in  N_DIGITS  decimal point per digit, 1=lit
blank_lz  in  1  leading-zero blanking enable
ready  out  1  update slot free
an  out  N_DIGITS  anode enables, active-low
sseg  out  8  {dp,a,b,c,d,e,f,g}, active-low
frame_tick  out  1  one-cycle pulse per completed frame

Behaviour:
- Clock and reset: single clock, clk. reset is synchronous and active-high.
- Reset state (one cycle after reset is sampled high):
  - an all 1, sseg=8'hFF, ready=1, frame_tick=0;
  - prescaler cnt=0, digit idx=0;
  - active and shadow registers cleared to 0;
  - any pending update is discarded.
  - Reset mid-operation behaves identically.
- Prescaler (en=1):
  - cnt counts 0..PRESCALE-1.
  - At cnt=PRESCALE-1, cnt wraps to 0 and idx advances.
  - idx wraps from N_DIGITS-1 to 0. That wrap cycle is the frame boundary.
- Outputs: an, sseg and frame_tick are registered and reflect the (cnt, idx) state of the previous cycle (1-cycle latency).
  - frame_tick=1 exactly one cycle after each frame boundary.
- Guard: while cnt < GUARD, an all 1 and sseg=8'hFF. Otherwise:
  - an[idx]=0, all other anodes 1;
  - sseg[6:0] = decode(active nibble idx);
  - sseg[7] = ~active_dp[idx].
- Decode, active-low a..g:
  - 0:0000001, 1:1001111, 2:0010010, 3:0000110, 4:1001100, 5:0100100, 6:0100000, 7:0001111;
  - 8:0000000, 9:0000100, A:0001000, b:1100000, C:0110001, d:1000010, E:0110000, F:0111000.
  - All 16 codes are defined; no latch, no X.
- Leading-zero blanking: when blank_lz=1, digit k (k>=1) is blanked if nibbles k..N_DIGITS-1 are all 0.
  - Blanked means sseg[6:0]=7'h7F; dp is still honoured.
  - Digit 0 is never blanked.
- Handshake:
  - load && ready: value/dp_in are captured into the shadow register, and ready<=0 (pending).
  - load && !ready: ignored; shadow is unchanged.
- Applying a pending update:
  - With en=1, pending shadow is copied to active at the frame boundary cycle, and ready<=1 on the same edge.
  - Load accepted on the frame boundary cycle itself is not applied then; it waits for the next boundary.
- en=0:
  - cnt and idx hold; an all 1, sseg=8'hFF, frame_tick=0.
  - A pending shadow is copied to active on the next edge, with ready<=1.
  - Load is still accepted.
- en 0->1: scanning resumes from the held cnt/idx.

Decomposition:
- Shared package seg7_pkg:
  - SEG_BLANK=8'hFF and SEG_OFF7=7'h7F;
  - 16-entry active-low segment constant table;
  - nibble width constant 4.
- Sub-module hex_seg7_decode: combinational 4-bit to 7-bit active-low decoder, full case, instantiated once and driven by the idx-selected nibble.

Test Plan:
All scenarios use N_DIGITS=4, PRESCALE=4, GUARD=1.
1. Reset, en=1, load value=16'h1234, dp_in=0 -> after the next frame boundary, each slot shows 1 cycle of an=4'hF, then 3 cycles of an=4'hE/sseg=8'hCC (digit 0 "4"), an=4'hD/sseg=8'h86, an=4'hB/sseg=8'h92, an=4'h7/sseg=8'hCF. frame_tick pulses every 16 cycles.
2. Load with ready=1, then load again with value=16'hFFFF before the boundary -> second load is ignored, ready stays 0 until the boundary, and the display shows the first value.
3. value=16'h0050, blank_lz=1, dp_in=4'b0001 -> digits 3 and 2 show sseg=8'hFF, digit 1 shows 8'hA4, digit 0 shows 8'h01 (decimal point lit). With blank_lz=0, digit 3 shows 8'h81.
4. Load asserted exactly on the frame boundary cycle -> the value appears only at the next boundary, 16 cycles later, and ready rises with it.
5. en=0 mid-slot with a pending load -> an=4'hF and sseg=8'hFF while disabled, ready=1 after one cycle. Re-enabling resumes the same idx/cnt showing the new value.
6. reset pulsed mid-frame with an update pending -> next cycle an=4'hF, sseg=8'hFF, ready=1, display 0000 afterward.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan controller: blanking codes, the
// active-low hex segment table ({a,b,c,d,e,f,g}) and the nibble width.
package seg7_pkg;

    localparam int unsigned NIB_W     = 4;
    localparam logic [7:0]  SEG_BLANK = 8'hFF;
    localparam logic [6:0]  SEG_OFF7  = 7'h7F;

    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

endpackage

// File: rtl/hex_seg7_decode.sv
// Combinational hex nibble to active-low {a..g} segment decoder.
module hex_seg7_decode
    import seg7_pkg::*;
(
    input  logic [NIB_W-1:0] nib_i,
    output logic [6:0]       seg_o
);

    always_comb begin
        seg_o = SEG_OFF7;
        unique case (nib_i)
            4'h0: seg_o = SEG_TABLE[0];
            4'h1: seg_o = SEG_TABLE[1];
            4'h2: seg_o = SEG_TABLE[2];
            4'h3: seg_o = SEG_TABLE[3];
            4'h4: seg_o = SEG_TABLE[4];
            4'h5: seg_o = SEG_TABLE[5];
            4'h6: seg_o = SEG_TABLE[6];
            4'h7: seg_o = SEG_TABLE[7];
            4'h8: seg_o = SEG_TABLE[8];
            4'h9: seg_o = SEG_TABLE[9];
            4'hA: seg_o = SEG_TABLE[10];
            4'hB: seg_o = SEG_TABLE[11];
            4'hC: seg_o = SEG_TABLE[12];
            4'hD: seg_o = SEG_TABLE[13];
            4'hE: seg_o = SEG_TABLE[14];
            4'hF: seg_o = SEG_TABLE[15];
        endcase
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed common-anode 7-segment scan controller with guard slots,
// leading-zero blanking and a frame-aligned ready/load update handshake.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int unsigned N_DIGITS = 4,
    parameter int unsigned PRESCALE = 50000,
    parameter int unsigned GUARD    = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic                      load,
    input  logic [NIB_W*N_DIGITS-1:0] value,
    input  logic [N_DIGITS-1:0]       dp_in,
    input  logic                      blank_lz,
    output logic                      ready,
    output logic [N_DIGITS-1:0]       an,
    output logic [7:0]                sseg,
    output logic                      frame_tick
);

    localparam int unsigned CNT_W = $clog2(PRESCALE);
    localparam int unsigned IDX_W = $clog2(N_DIGITS);

    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [NIB_W*N_DIGITS-1:0] act_val_q, act_val_d, shd_val_q, shd_val_d;
    logic [N_DIGITS-1:0]       act_dp_q, act_dp_d, shd_dp_q, shd_dp_d;
    logic                      ready_q, ready_d;
    logic [N_DIGITS-1:0]       an_q, an_d;
    logic [7:0]                sseg_q, sseg_d;
    logic                      frame_tick_q, frame_tick_d;

    logic                      last_cnt, last_idx, boundary;
    logic [NIB_W-1:0]          cur_nib;
    logic [6:0]                cur_seg;
    logic [N_DIGITS-1:0]       zero_above;

    always_comb begin
        last_cnt = (cnt_q == CNT_W'(PRESCALE - 1));
        last_idx = (idx_q == IDX_W'(N_DIGITS - 1));
        boundary = en && last_cnt && last_idx;

        cnt_d = cnt_q;
        idx_d = idx_q;
        if (en) begin
            if (last_cnt) begin
                cnt_d = '0;
                idx_d = last_idx ? '0 : idx_q + 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Accept and apply are exclusive: accept needs ready=1, apply needs ready=0.
    always_comb begin
        shd_val_d = shd_val_q;
        shd_dp_d  = shd_dp_q;
        act_val_d = act_val_q;
        act_dp_d  = act_dp_q;
        ready_d   = ready_q;
        if (load && ready_q) begin
            shd_val_d = value;
            shd_dp_d  = dp_in;
            ready_d   = 1'b0;
        end else if (!ready_q && (boundary || !en)) begin
            act_val_d = shd_val_q;
            act_dp_d  = shd_dp_q;
            ready_d   = 1'b1;
        end
    end

    assign cur_nib = act_val_q[idx_q*NIB_W +: NIB_W];

    hex_seg7_decode u_decode (
        .nib_i (cur_nib),
        .seg_o (cur_seg)
    );

    // zero_above[k]: nibbles k..N_DIGITS-1 of the active value are all zero.
    always_comb begin
        zero_above = '0;
        zero_above[N_DIGITS-1] = (act_val_q[(N_DIGITS-1)*NIB_W +: NIB_W] == '0);
        for (int k = N_DIGITS - 2; k >= 0; k--) begin
            zero_above[k] = zero_above[k+1] && (act_val_q[k*NIB_W +: NIB_W] == '0);
        end
    end

    always_comb begin
        an_d         = '1;
        sseg_d       = SEG_BLANK;
        frame_tick_d = boundary;
        if (en && (32'(cnt_q) >= GUARD)) begin
            an_d[idx_q] = 1'b0;
            sseg_d[7]   = ~act_dp_q[idx_q];
            if (blank_lz && (idx_q != '0) && zero_above[idx_q]) begin
                sseg_d[6:0] = SEG_OFF7;
            end else begin
                sseg_d[6:0] = cur_seg;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            act_val_q    <= '0;
            act_dp_q     <= '0;
            shd_val_q    <= '0;
            shd_dp_q     <= '0;
            ready_q      <= 1'b1;
            an_q         <= '1;
            sseg_q       <= SEG_BLANK;
            frame_tick_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            act_val_q    <= act_val_d;
            act_dp_q     <= act_dp_d;
            shd_val_q    <= shd_val_d;
            shd_dp_q     <= shd_dp_d;
            ready_q      <= ready_d;
            an_q         <= an_d;
            sseg_q       <= sseg_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign ready      = ready_q;
    assign an         = an_q;
    assign sseg       = sseg_q;
    assign frame_tick = frame_tick_q;

endmodule
